// File: rtl/serial_deser_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, stop bit, sampled on enable strobes.
// Optional even parity bit between data and stop when SERIAL_DESER_RX_PARITY_EN is defined.
module serial_deser_rx #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              serialin,
  input  logic              readack,
  input  logic              clearerr,
  output logic [DATA_W-1:0] parallelout,
  output logic              dataready,
  output logic              busy,
  output logic              frameerr,
  output logic              overrun,
  output logic              parityerr
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] pout_nxt;
  logic              rdy_nxt;
  logic              ferr_nxt;
  logic              ovr_nxt;
  logic              load;
  logic              set_ferr;
  logic              set_ovr;
  logic              set_perr;
  logic              par_ok;

`ifdef SERIAL_DESER_RX_PARITY_EN
  logic perr_q, perr_nxt;
  logic par_bad, par_bad_nxt;

  assign par_ok    = ~par_bad;
  assign parityerr = perr_q;
`else
  assign par_ok    = 1'b1;
  assign parityerr = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    pout_nxt  = parallelout;
    rdy_nxt   = dataready;
    load      = 1'b0;
    set_ferr  = 1'b0;
    set_ovr   = 1'b0;
    set_perr  = 1'b0;
`ifdef SERIAL_DESER_RX_PARITY_EN
    par_bad_nxt = par_bad;
`endif

    if (enable) begin
      case (state)
        IDLE: begin
          if (!serialin) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          sh_nxt  = {serialin, sh[DATA_W-1:1]};
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(DATA_W - 1)) begin
`ifdef SERIAL_DESER_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
`ifdef SERIAL_DESER_RX_PARITY_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_nxt = ^{sh, serialin};
          set_perr    = ^{sh, serialin};
          state_nxt   = STOP;
        end
`endif
        STOP: begin
          state_nxt = IDLE;
          if (!serialin) begin
            set_ferr = 1'b1;
          end else if (par_ok) begin
            if (!dataready || readack) begin
              load = 1'b1;
            end else begin
              set_ovr = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // A completing word takes priority over a plain acknowledge.
    if (load) begin
      pout_nxt = sh;
      rdy_nxt  = 1'b1;
    end else if (readack && dataready) begin
      rdy_nxt  = 1'b0;
    end

    ferr_nxt = set_ferr | (frameerr & ~clearerr);
    ovr_nxt  = set_ovr  | (overrun  & ~clearerr);
`ifdef SERIAL_DESER_RX_PARITY_EN
    perr_nxt = set_perr | (perr_q & ~clearerr);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      parallelout <= '0;
      dataready   <= 1'b0;
      frameerr    <= 1'b0;
      overrun     <= 1'b0;
`ifdef SERIAL_DESER_RX_PARITY_EN
      perr_q      <= 1'b0;
      par_bad     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      sh          <= sh_nxt;
      cnt         <= cnt_nxt;
      parallelout <= pout_nxt;
      dataready   <= rdy_nxt;
      frameerr    <= ferr_nxt;
      overrun     <= ovr_nxt;
`ifdef SERIAL_DESER_RX_PARITY_EN
      perr_q      <= perr_nxt;
      par_bad     <= par_bad_nxt;
`endif
    end
  end

`ifndef SERIAL_DESER_RX_PARITY_EN
  logic unused_perr;
  assign unused_perr = set_perr;
`endif

endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx (DATA_W = 4): vector table for the basic flow, scoreboarded frame sequences after.
module tb_serial_deser_rx;

`ifdef SERIAL_DESER_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       serialin = 1'b1;
  logic       readack = 1'b0;
  logic       clearerr = 1'b0;
  logic [3:0] parallelout;
  logic       dataready, busy, frameerr, overrun, parityerr;

  serial_deser_rx #(.DATA_W(4)) dut (
    .clock(clk), .reset(reset), .enable(enable), .serialin(serialin),
    .readack(readack), .clearerr(clearerr), .parallelout(parallelout),
    .dataready(dataready), .busy(busy), .frameerr(frameerr),
    .overrun(overrun), .parityerr(parityerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, ser, ack, clr;
    logic [3:0] pout;
    logic       drdy, bsy, ferr, ovr;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] expq[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [3:0] exp_pout;
  logic       exp_drdy, exp_ferr, exp_ovr, exp_perr;

  function automatic void add(input logic rst, en, ser, ack, clr, input logic [3:0] pout,
                              input logic drdy, bsy, ferr, ovr);
    vec_t v;
    v = '{rst, en, ser, ack, clr, pout, drdy, bsy, ferr, ovr};
    vecs.push_back(v);
  endfunction

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Disabled cycles drive the inverted bit so an ignored enable corrupts the word.
  task automatic strobe(input logic b, input int gap, input logic ack, input logic clr);
    for (int g = 0; g < gap; g++) begin
      enable = 1'b0; serialin = ~b; readack = 1'b0; clearerr = 1'b0;
      @(posedge clk); #1;
    end
    enable = 1'b1; serialin = b; readack = ack; clearerr = clr;
    @(posedge clk); #1;
    enable = 1'b0; serialin = 1'b1; readack = 1'b0; clearerr = 1'b0;
  endtask

  task automatic pulse(input logic ack, input logic clr);
    enable = 1'b0; readack = ack; clearerr = clr;
    @(posedge clk); #1;
    readack = 1'b0; clearerr = 1'b0;
    if (ack && exp_drdy) exp_drdy = 1'b0;
    if (clr) begin exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0; end
    chk1("pulse.drdy", dataready, exp_drdy);
    chk4("pulse.pout", parallelout, exp_pout);
    chk1("pulse.ferr", frameerr, exp_ferr);
    chk1("pulse.ovr", overrun, exp_ovr);
    chk1("pulse.perr", parityerr, exp_perr);
  endtask

  task automatic send_frame(input string name, input logic [3:0] d, input logic stop,
                            input logic par, input logic ack, input logic clr, input int gap);
    logic par_ok, good, ld;
    logic [3:0] got;
    par_ok = 1'b1;
    if (PAR_EN) par_ok = ~(^{d, par});
    good = stop && par_ok;
    ld   = 1'b0;
    if (clr) begin exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0; end
    if (!stop) exp_ferr = 1'b1;
    if (!par_ok) exp_perr = 1'b1;
    if (good) begin
      if (!exp_drdy || ack) begin
        ld = 1'b1; exp_pout = d; exp_drdy = 1'b1;
        expq.push_back(d);
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (ack && exp_drdy) begin
      exp_drdy = 1'b0;
    end

    strobe(1'b0, gap, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(d[i], gap, 1'b0, 1'b0);
    if (PAR_EN) strobe(par, gap, 1'b0, 1'b0);
    strobe(stop, gap, ack, clr);

    if (ld) begin
      got = expq.pop_front();
      chk4({name, ".sb_word"}, parallelout, got);
    end
    chk4({name, ".pout"}, parallelout, exp_pout);
    chk1({name, ".drdy"}, dataready, exp_drdy);
    chk1({name, ".busy"}, busy, 1'b0);
    chk1({name, ".ferr"}, frameerr, exp_ferr);
    chk1({name, ".ovr"}, overrun, exp_ovr);
    chk1({name, ".perr"}, parityerr, exp_perr);
  endtask

  initial begin
    // rst en ser ack clr | pout drdy busy ferr ovr
    add(1, 1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
    // 4'hA: start, 0,1,(stall),0,1, stop
    add(0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 4'h0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4'h0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 4'h0, 0, 1, 0, 0);
    if (PAR_EN) add(0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 4'hA, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4'hA, 0, 0, 0, 0);
    // bad stop after data 1,1,1,1 (parity 0 is even for 4'hF)
    add(0, 1, 0, 0, 0, 4'hA, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 4'hA, 0, 1, 0, 0);
    if (PAR_EN) add(0, 1, 0, 0, 0, 4'hA, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 4'hA, 0, 0, 1, 0);
    add(0, 1, 1, 0, 1, 4'hA, 0, 0, 0, 0);
    // good 4'hF
    add(0, 1, 0, 0, 0, 4'hA, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 4'hA, 0, 1, 0, 0);
    if (PAR_EN) add(0, 1, 0, 0, 0, 4'hA, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 4'hF, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; serialin = vecs[i].ser;
      readack = vecs[i].ack; clearerr = vecs[i].clr;
      @(posedge clk); #1;
      chk4($sformatf("vec%0d.pout", i), parallelout, vecs[i].pout);
      chk1($sformatf("vec%0d.drdy", i), dataready, vecs[i].drdy);
      chk1($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
      chk1($sformatf("vec%0d.ferr", i), frameerr, vecs[i].ferr);
      chk1($sformatf("vec%0d.ovr", i), overrun, vecs[i].ovr);
      chk1($sformatf("vec%0d.perr", i), parityerr, 1'b0);
    end
    reset = 1'b0; enable = 1'b0; serialin = 1'b1; readack = 1'b0; clearerr = 1'b0;

    exp_pout = 4'hF; exp_drdy = 1'b1;
    exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;

    pulse(1'b1, 1'b0);                                 // ack while enable low
    send_frame("w3", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_frame("ovr5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    pulse(1'b0, 1'b1);
    send_frame("ack5", 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    send_frame("gap6", 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    send_frame("ferr_clr", 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    pulse(1'b0, 1'b1);

    // reset after two data bits
    strobe(1'b0, 0, 1'b0, 1'b0);
    strobe(1'b1, 0, 1'b0, 1'b0);
    strobe(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1; enable = 1'b1; serialin = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0; serialin = 1'b1;
    exp_pout = 4'h0; exp_drdy = 1'b0;
    exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    chk4("rst.pout", parallelout, 4'h0);
    chk1("rst.drdy", dataready, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.ferr", frameerr, 1'b0);
    chk1("rst.ovr", overrun, 1'b0);
    chk1("rst.perr", parityerr, 1'b0);

    send_frame("post_rst9", 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_frame("b2bC", 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    send_frame("parA_ok", 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    send_frame("parA_bad", 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    chk4("sb_empty", 4'(expq.size()), 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_deser_rx.md
Name: serial_deser_rx

Overview:
- Serial-to-parallel frame receiver.
- It is the receiving end of the shift-right serial stream produced by the 4-bit shift register's `serialoutr` (LSB first).
- Samples one bit per `enable` strobe and assembles framed words (start bit, `DATA_W` data bits, stop bit).
- Presents each good word on a parallel bus with a level `dataready`/`readack` handshake, and flags framing and overrun errors.

Parameters:
- `DATA_W`, default 4: data bits per frame, legal range 2..16.

Ports:
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: bit strobe; `serialin` is sampled only on clocks where `enable` = 1.
- `serialin` input 1: serial data; line idles at 1.
- `readack` input 1: consumer acknowledge; clears `dataready`.
- `clearerr` input 1: clears the sticky error flags.
- `parallelout` output `DATA_W`: last good received word.
- `dataready` output 1: high while `parallelout` holds an unconsumed word.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).
- `frameerr` output 1: sticky; stop bit sampled as 0.
- `overrun` output 1: sticky; good frame completed while the previous word was unconsumed.
- `parityerr` output 1: sticky parity mismatch (see Optional Feature).

Behaviour:
- Reset (synchronous, `reset` = 1 at a rising edge): state = IDLE, `parallelout` = 0, `dataready` = 0, `busy` = 0, `frameerr` = 0, `overrun` = 0, `parityerr` = 0, internal shift register = 0, bit counter = 0.
- Reset mid-frame aborts the frame with no flag set; reset has priority over every other input.
- All transitions below occur only on clocks with `enable` = 1. With `enable` = 0, the FSM, shift register and counter hold. `readack`/`clearerr` are honoured regardless of `enable`.
- IDLE: if `serialin` = 0 (start bit), go to DATA with bitcnt = 0; otherwise stay.
- DATA:
  - shift `sh` = {`serialin`, `sh[DATA_W-1:1]`}, so the first data bit ends up in bit 0;
  - bitcnt++;
  - after the `DATA_W`-th bit, go to STOP (or PARITY when the feature is enabled).
- STOP, `serialin` = 1 (good frame):
  - if `dataready` = 0, or `readack` = 1 in the same cycle: `parallelout` <= `sh`, `dataready` <= 1;
  - else: `overrun` <= 1, word discarded, `parallelout` unchanged, `dataready` stays 1;
  - then go to IDLE.
- STOP, `serialin` = 0: `frameerr` <= 1, word discarded, go to IDLE. The low stop bit is not reused as a start bit.
- Latency: `parallelout`/`dataready` change on the edge that samples the stop bit. A frame occupies `DATA_W`+2 strobes (+1 with parity).
- `readack` = 1 with `dataready` = 1 and no completion in the same cycle: `dataready` <= 0, `parallelout` holds. `readack` with `dataready` = 0 is ignored.
- `clearerr` = 1 clears `frameerr`, `overrun` and `parityerr`. If an error sets in the same cycle, set wins.
- Back-to-back frames: a start bit may be sampled on the strobe immediately after the stop bit.

Optional Feature:
- Macro: `SERIAL_DESER_RX_PARITY_EN`.
- Defined:
  - PARITY state inserted between DATA and STOP; one bit is sampled there.
  - Even parity: XOR of data bits and parity bit must be 0.
  - On mismatch: `parityerr` <= 1; the frame still runs through STOP, but the word is discarded (no load, no overrun).
  - A parity and framing error in the same frame sets both flags.
- Undefined:
  - no PARITY state; frame length is `DATA_W`+2;
  - `parityerr` port present but tied to 0.

Test Plan (`DATA_W` = 4, `enable` = 1 every cycle unless noted):
- Reset, then `serialin` = 1 for 10 cycles -> `busy` = 0, `dataready` = 0, `parallelout` = 4'h0, all flags 0.
- Send 0,0,1,0,1,1 -> `parallelout` = 4'hA and `dataready` = 1 after the stop-bit edge. Pulse `readack` -> `dataready` = 0, `parallelout` stays 4'hA.
- Send frame 4'h3, no `readack`, then frame 4'h5 -> `overrun` = 1, `parallelout` = 4'h3. Repeat with `readack` on the second stop-bit cycle -> `parallelout` = 4'h5, `overrun` = 0.
- Send 0,1,1,1,1,0 (bad stop) -> `frameerr` = 1, `dataready` unchanged. `clearerr` -> `frameerr` = 0. A following good frame 4'hF loads normally.
- Toggle `enable` 1-of-3 cycles while sending 4'h6 -> `parallelout` = 4'h6. Assert `reset` after 2 data bits -> all outputs 0 and `busy` = 0 next cycle, with no flags set.
- `SERIAL_DESER_RX_PARITY_EN`: 4'hA with parity 0 -> loads. 4'hA with parity 1 -> `parityerr` = 1, no load.
